// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: redirect/stall control from decode, ROM address/data,
// and the instruction pair handed to decode.
interface fetch_unit_if;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [9:0]  rom_addr1;
    logic [9:0]  rom_addr2;
    logic [31:0] rom_instr1;
    logic [31:0] rom_instr2;
    logic        if_valid1;
    logic        if_valid2;
    logic [31:0] if_pc1;
    logic [31:0] if_pc2;
    logic [31:0] if_instr1;
    logic [31:0] if_instr2;

    // Fetch unit side
    modport master (
        input  stall, redirect_valid, redirect_pc, rom_instr1, rom_instr2,
        output rom_addr1, rom_addr2, if_valid1, if_valid2,
               if_pc1, if_pc2, if_instr1, if_instr2
    );

    // Decode / ROM side
    modport slave (
        output stall, redirect_valid, redirect_pc, rom_instr1, rom_instr2,
        input  rom_addr1, rom_addr2, if_valid1, if_valid2,
               if_pc1, if_pc2, if_instr1, if_instr2
    );
endinterface

// File: rtl/fetch_unit.sv
// Dual-issue instruction fetch: owns the PC, addresses the registered ROM
// and pairs its outputs with PCs and valid flags for decode.
// Optional JAL predecode redirection is built when JAL_PREDECODE_EN is defined.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    logic [31:0] pc_q;
    logic [31:0] out_pc_q;
    logic        out_valid_q;
    logic [31:0] req_pc;
    logic        pair_valid;
    logic        jal_take;
    logic [31:0] jal_target;
    logic        kill_slot2;

`ifdef JAL_PREDECODE_EN
    // J-type immediate, sign-extended to 32 bits
    function automatic logic [31:0] j_imm(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    // Predecode the pair on the ROM outputs; slot 1 JAL wins over slot 2
    always_comb begin
        jal_take   = 1'b0;
        jal_target = '0;
        kill_slot2 = 1'b0;
        if (out_valid_q && !bus.stall && !bus.redirect_valid) begin
            if (bus.rom_instr1[6:0] == 7'b1101111) begin
                jal_take   = 1'b1;
                jal_target = out_pc_q + j_imm(bus.rom_instr1);
                kill_slot2 = 1'b1;
            end else if (bus.rom_instr2[6:0] == 7'b1101111) begin
                jal_take   = 1'b1;
                jal_target = out_pc_q + 32'd4 + j_imm(bus.rom_instr2);
            end
        end
    end
`else
    // No predecode: JALs are resolved downstream through redirect
    always_comb begin
        jal_take   = 1'b0;
        jal_target = '0;
        kill_slot2 = 1'b0;
    end
`endif

    // Request PC selection; a held stall re-reads the same pair from the ROM
    always_comb begin
        req_pc = pc_q;
        if (rst)
            req_pc = RESET_PC;
        else if (bus.redirect_valid)
            req_pc = bus.redirect_pc & ~32'd3;
        else if (bus.stall && out_valid_q)
            req_pc = out_pc_q;
        else if (jal_take)
            req_pc = jal_target;
    end

    // PC and output-pair tracking registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            out_pc_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            pc_q        <= req_pc + 32'd8;
            out_pc_q    <= req_pc;
            out_valid_q <= 1'b1;
        end
    end

    // Output assembly
    always_comb begin
        pair_valid    = out_valid_q & ~bus.redirect_valid & ~rst;
        bus.rom_addr1 = req_pc[11:2];
        bus.rom_addr2 = req_pc[11:2] + 10'd1;
        bus.if_valid1 = pair_valid;
        bus.if_valid2 = pair_valid & ~kill_slot2;
        bus.if_pc1    = out_pc_q;
        bus.if_pc2    = out_pc_q + 32'd4;
        bus.if_instr1 = bus.rom_instr1;
        bus.if_instr2 = bus.rom_instr2;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: per-cycle vector table plus
// hand-written JAL predecode sequences (JAL_PREDECODE_EN aware).
module tb_fetch_unit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ROM model
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        bus.rom_instr1 <= mem[bus.rom_addr1];
        bus.rom_instr2 <= mem[bus.rom_addr2];
    end

    // Non-JAL filler word tagged with its own address
    function automatic logic [31:0] rom_word(input logic [9:0] a);
        return {2'b01, a, 13'h0, 7'h13};
    endfunction

    function automatic logic [31:0] jal_enc(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic [9:0]  addr1;
        logic        v1;
        logic [31:0] pc1;
    } vec_t;

    vec_t vecs [17];

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] pc2;
        checks = 0;
        errors = 0;
        for (int unsigned i = 0; i < 1024; i++) mem[i] = rom_word(10'(i));

        //         rst   stall rv    rpc            addr1    v1    pc1
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h0,        10'h000, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        10'h000, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        10'h002, 1'b1, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,        10'h004, 1'b1, 32'h8};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,        10'h004, 1'b1, 32'h10};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,        10'h004, 1'b1, 32'h10};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,        10'h004, 1'b1, 32'h10};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        10'h006, 1'b1, 32'h10};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        10'h008, 1'b1, 32'h18};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 32'h103,      10'h040, 1'b0, 32'h20};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        10'h042, 1'b1, 32'h100};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 32'h200,      10'h080, 1'b0, 32'h108};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 32'hFFC,      10'h3FF, 1'b0, 32'h200};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,        10'h001, 1'b1, 32'hFFC};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 32'h0,        10'h000, 1'b0, 32'h1004};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 32'h0,        10'h000, 1'b0, 32'h0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,        10'h002, 1'b1, 32'h0};

        rst = 1'b1;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            rst                = vecs[i].rst;
            bus.stall          = vecs[i].stall;
            bus.redirect_valid = vecs[i].rv;
            bus.redirect_pc    = vecs[i].rpc;
            @(negedge clk);
            pc2 = vecs[i].pc1 + 32'd4;
            chk($sformatf("v%0d addr1", i), 32'(bus.rom_addr1), 32'(vecs[i].addr1));
            chk($sformatf("v%0d addr2", i), 32'(bus.rom_addr2), 32'(10'(vecs[i].addr1 + 10'd1)));
            chk($sformatf("v%0d valid1", i), 32'(bus.if_valid1), 32'(vecs[i].v1));
            chk($sformatf("v%0d valid2", i), 32'(bus.if_valid2), 32'(vecs[i].v1));
            chk($sformatf("v%0d pc1", i), bus.if_pc1, vecs[i].pc1);
            chk($sformatf("v%0d pc2", i), bus.if_pc2, pc2);
            if (vecs[i].v1) begin
                chk($sformatf("v%0d instr1", i), bus.if_instr1, rom_word(vecs[i].pc1[11:2]));
                chk($sformatf("v%0d instr2", i), bus.if_instr2, rom_word(pc2[11:2]));
            end
            @(posedge clk);
            #1;
        end

        // Slot 1 JAL (+0x40) at pc 0x20
        mem[8] = jal_enc(21'h000040);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h20;
        @(negedge clk);
        chk("jal1 redirect cycle invalid", 32'(bus.if_valid1), 32'h0);
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("jal1 pc1", bus.if_pc1, 32'h20);
        chk("jal1 valid1", 32'(bus.if_valid1), 32'h1);
`ifdef JAL_PREDECODE_EN
        chk("jal1 valid2 killed", 32'(bus.if_valid2), 32'h0);
        chk("jal1 target addr1", 32'(bus.rom_addr1), 32'h18);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("jal1 next pc1", bus.if_pc1, 32'h60);
        chk("jal1 next pc2", bus.if_pc2, 32'h64);
        chk("jal1 next valid2", 32'(bus.if_valid2), 32'h1);
`else
        chk("jal1 valid2 unmasked", 32'(bus.if_valid2), 32'h1);
        chk("jal1 sequential addr1", 32'(bus.rom_addr1), 32'hA);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("jal1 next pc1", bus.if_pc1, 32'h28);
`endif
        @(posedge clk);
        #1;

        // Slot 2 JAL (-8) at pc 0x24
        mem[8] = rom_word(10'd8);
        mem[9] = jal_enc(21'h1FFFF8);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h20;
        @(posedge clk);
        #1;
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("jal2 pc1", bus.if_pc1, 32'h20);
        chk("jal2 valid1", 32'(bus.if_valid1), 32'h1);
        chk("jal2 valid2", 32'(bus.if_valid2), 32'h1);
`ifdef JAL_PREDECODE_EN
        chk("jal2 target addr1", 32'(bus.rom_addr1), 32'h7);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("jal2 next pc1", bus.if_pc1, 32'h1C);
        chk("jal2 next pc2", bus.if_pc2, 32'h20);
`else
        chk("jal2 sequential addr1", 32'(bus.rom_addr1), 32'hA);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("jal2 next pc1", bus.if_pc1, 32'h28);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Dual-issue instruction fetch stage sitting directly upstream of the instruction ROM. It owns the program counter, drives both ROM word addresses every cycle, and pairs the ROM's registered instruction outputs with their PCs and valid flags for decode. It handles downstream stall, external redirect/flush, and, optionally, JAL predecode redirection.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  decode cannot accept the current pair; hold it
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  restart address; bits [1:0] ignored (treated as 0)
- rom_addr1  out  10  ROM word address, slot 1 (= req_pc[11:2])
- rom_addr2  out  10  ROM word address, slot 2 (= rom_addr1 + 1, mod 1024)
- rom_instr1  in  32  ROM output for the address presented on the previous edge
- rom_instr2  in  32  ROM output, slot 2
- if_valid1  out  1  slot 1 pair entry valid
- if_valid2  out  1  slot 2 entry valid
- if_pc1  out  32  PC of if_instr1
- if_pc2  out  32  PC of if_instr2 (= if_pc1 + 4)
- if_instr1  out  32  pass-through of rom_instr1
- if_instr2  out  32  pass-through of rom_instr2

## Operation
- State: pc_q (next sequential request PC), out_pc_q (PC of the pair currently on rom_instr*), out_valid_q.
- Request PC, combinational, priority order:
  - redirect_valid -> {redirect_pc[31:2], 2'b00}
  - stall && out_valid_q -> out_pc_q (ROM re-reads the same pair, so outputs stay stable; no skid buffer is needed)
  - JAL_PREDECODE_EN redirect (see Configuration)
  - otherwise -> pc_q
- rom_addr1 = req_pc[11:2]; during rst, req_pc = RESET_PC.
- Each edge with rst low: out_pc_q <= req_pc; out_valid_q <= 1; pc_q <= req_pc + 8 (32-bit, wraps mod 2^32).
- if_pc1 = out_pc_q; if_pc2 = out_pc_q + 4.
- if_valid1 = out_valid_q & ~redirect_valid & ~rst.
- if_valid2 = the same, further masked by predecode (Configuration).
- A pair is consumed on a cycle where if_valid1 && !stall.
- Stall with out_valid_q = 0 (first cycle after reset) does not hold; the fetch proceeds normally.
- Unaligned pairs are legal: pc = 4 fetches words 1 and 2. Word 1023 pairs with word 0.

## Timing
- Reset (edge with rst high): out_valid_q = 0, pc_q = RESET_PC, out_pc_q = 0.
  - if_valid1/2 = 0 while rst is high and for the first cycle after release.
- Latency: the request presented in cycle N appears on if_* in cycle N+1. The first valid pair is in the second cycle after rst falls.
- Steady state: one pair (8 bytes) per cycle.
- Redirect in cycle N:
  - cycle N outputs are invalid.
  - the redirect target pair is valid in cycle N+1.
  - redirect overrides stall.
- Back-to-back redirects: each is honored, and only the last target's data becomes valid.
- rst asserted mid-stream: outputs go invalid in that same cycle, and restart follows the reset sequence.

## Configuration
- JAL_PREDECODE_EN defined: when out_valid_q && !stall && !redirect_valid, the unit predecodes the current pair.
  - If rom_instr1[6:0] == 7'b1101111:
    - target = if_pc1 + sext({imm[20], imm[19:12], imm[11], imm[10:1], 0})
    - if_valid2 is forced to 0
    - req_pc = target
  - Else if rom_instr2 is JAL: req_pc = if_pc2 + its J-immediate; both slots stay valid.
  - Slot 1 has priority.
  - External redirect still has highest priority.
- JAL_PREDECODE_EN undefined:
  - no predecode logic is built.
  - if_valid2 == if_valid1.
  - JALs are resolved downstream via redirect_valid.

## Test plan
- Reset release, RESET_PC = 0, no stall -> rom_addr1 = 0, 2, 4 on successive cycles. First valid pair is pc 0/4, then 8/12; rom_addr2 = rom_addr1 + 1.
- Stall held for 3 cycles while showing pc 0x10/0x14 -> rom_addr1 stays 4, and if_pc1/if_instr* are unchanged for all 3 cycles. On release, the next pair is 0x18.
- redirect_valid with redirect_pc = 0x103 during a stall -> that cycle's if_valid1/2 = 0, next cycle if_pc1 = 0x100, if_pc2 = 0x104.
- pc = 0xFFC -> rom_addr1 = 1023, rom_addr2 = 0, if_pc2 = 0x1000.
- JAL_PREDECODE_EN, slot 1 = JAL with offset +0x40 at pc 0x20 -> if_valid2 = 0, and the next pair has pc 0x60/0x64.
- JAL_PREDECODE_EN, slot 2 = JAL with offset -8 at pc 0x24 -> both slots valid, and the next pair has pc 0x1C.
- rst pulsed mid-stream -> outputs invalid that cycle, then refetch from RESET_PC with 1-cycle latency.
